// File: rtl/param_down_sampler_pkg.sv
// -----------------------------------------------------------------------------
// param_down_sampler_pkg
// Shared definitions for the down-sampler slice: output mode encoding, the
// input-side FSM state encoding and the accumulator width derivation.
// -----------------------------------------------------------------------------
package param_down_sampler_pkg;

    // mode input encoding
    localparam logic MODE_DECIMATE = 1'b0;  // keep top-left pixel of each block
    localparam logic MODE_AVERAGE  = 1'b1;  // box-average of each block

    // Input-side frame tracking FSM
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Width needed to sum FACTOR x FACTOR pixels of data_w bits without overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned factor);
        return data_w + 2 * $clog2(factor);
    endfunction

endpackage

// File: rtl/param_down_sampler_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with registered occupancy.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (empties the FIFO)
//   wr_en    write request
//   wr_data  write data
//   full     occupancy == DEPTH
//   rd_en    read request (pops the word shown on rd_data)
//   rd_data  head-of-queue word, valid whenever empty is low
//   empty    occupancy == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_wr, do_rd;

    always_comb begin
        full  = (count_q == (AW+1)'(DEPTH));
        empty = (count_q == '0);
        do_wr = wr_en && !full;
        do_rd = rd_en && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rd_data = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/param_down_sampler.sv
// -----------------------------------------------------------------------------
// param_down_sampler
// Streams a raster image in and emits a FACTOR x FACTOR down-sampled image,
// either by decimation (top-left pixel of each block) or by box-averaging.
// Output words carry end-of-row / end-of-frame flags through a FWFT FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   s_data     input pixel
//   s_valid    input pixel valid
//   s_ready    input ready
//   s_sof      first pixel of a frame
//   mode       0 decimate, 1 box-average (latched on the s_sof transfer)
//   m_data     output pixel
//   m_valid    output valid
//   m_ready    output ready
//   m_eol      last output of a row
//   m_eof      last output of a frame
//   frame_err  one-cycle pulse when s_sof arrives mid-frame
// -----------------------------------------------------------------------------
module param_down_sampler
    import param_down_sampler_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_W      = 1600,
    parameter int unsigned IMG_H      = 1200,
    parameter int unsigned FACTOR     = 2,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic              mode,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_eol,
    output logic              m_eof,
    output logic              frame_err
);

    localparam int unsigned LOG_F = $clog2(FACTOR);
    localparam int unsigned SHIFT = 2 * LOG_F;
    localparam int unsigned ACC_W = acc_width(DATA_W, FACTOR);
    localparam int unsigned NBLK  = IMG_W / FACTOR;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int unsigned FW    = DATA_W + 2;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               mode_q, mode_d;
    logic               frame_err_q, frame_err_d;

    logic [ACC_W-1:0]   line_acc [NBLK];

    logic               xfer, process, restart_err;
    logic [COL_W-1:0]   eff_col;
    logic [ROW_W-1:0]   eff_row;
    logic               eff_mode;
    logic [LOG_F-1:0]   col_sub, row_sub;
    logic               blk_first, blk_last, last_col, last_row;
    logic [BLK_W-1:0]   blk_idx;
    logic [ACC_W-1:0]   acc_sum;
    logic               acc_we;

    logic               fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [FW-1:0]      fifo_wdata, fifo_rdata;
    logic [DATA_W-1:0]  out_data;
    logic               out_eol, out_eof, out_en;

    // Out-of-frame pixels are always sinkable; anything that may land in the
    // FIFO waits for space.
    always_comb begin
        s_ready = !fifo_full || ((state_q == ST_IDLE) && !s_sof);
    end

    // A pixel carrying s_sof is processed as (0,0) with the incoming mode,
    // whether it opens a frame from IDLE or restarts one mid-frame.
    always_comb begin
        xfer        = s_valid && s_ready;
        process     = xfer && ((state_q == ST_ACTIVE) || s_sof);
        restart_err = xfer && s_sof && (state_q == ST_ACTIVE) &&
                      ((col_q != '0) || (row_q != '0));
        eff_col     = s_sof ? '0 : col_q;
        eff_row     = s_sof ? '0 : row_q;
        eff_mode    = s_sof ? mode : mode_q;

        col_sub     = eff_col[LOG_F-1:0];
        row_sub     = eff_row[LOG_F-1:0];
        blk_first   = (col_sub == '0) && (row_sub == '0);
        blk_last    = (col_sub == LOG_F'(FACTOR - 1)) && (row_sub == LOG_F'(FACTOR - 1));
        last_col    = (eff_col == COL_W'(IMG_W - 1));
        last_row    = (eff_row == ROW_W'(IMG_H - 1));
        blk_idx     = BLK_W'(eff_col >> LOG_F);

        // The first pixel of a block overwrites the entry, which also
        // discards any partial sum left by an aborted frame.
        acc_sum     = (blk_first ? '0 : line_acc[blk_idx]) + ACC_W'(s_data);
        acc_we      = process && (eff_mode == MODE_AVERAGE);

        if (eff_mode == MODE_AVERAGE) begin
            out_en   = blk_last;
            out_data = DATA_W'(acc_sum >> SHIFT);
            out_eol  = last_col;
            out_eof  = last_col && last_row;
        end else begin
            out_en   = blk_first;
            out_data = s_data;
            out_eol  = (eff_col == COL_W'(IMG_W - FACTOR));
            out_eof  = (eff_col == COL_W'(IMG_W - FACTOR)) &&
                       (eff_row == ROW_W'(IMG_H - FACTOR));
        end

        fifo_wr    = process && out_en;
        fifo_wdata = {out_eol, out_eof, out_data};
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        frame_err_d = 1'b0;
        if (process) begin
            state_d     = ST_ACTIVE;
            frame_err_d = restart_err;
            if (s_sof) mode_d = mode;
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = eff_row + 1'b1;
                end
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_DECIMATE;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_we) line_acc[blk_idx] <= acc_sum;
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    // Output fields are forced low while the FIFO is empty so flags never
    // show stale storage contents.
    always_comb begin
        m_valid = !fifo_empty;
        fifo_rd = m_valid && m_ready;
        if (m_valid) {m_eol, m_eof, m_data} = fifo_rdata;
        else         {m_eol, m_eof, m_data} = '0;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_param_down_sampler.sv
module tb_param_down_sampler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_sof, mode, m_ready, sel4;

    logic       s_valid_a, s_ready_a, m_valid_a, m_eol_a, m_eof_a, frame_err_a;
    logic [7:0] m_data_a;
    logic       s_valid_b, s_ready_b, m_valid_b, m_eol_b, m_eof_b, frame_err_b;
    logic [7:0] m_data_b;

    logic       s_ready_w, mv_w, ml_w, mf_w, fe_w;
    logic [7:0] md_w;

    assign s_valid_a = s_valid && !sel4;
    assign s_valid_b = s_valid && sel4;
    assign s_ready_w = sel4 ? s_ready_b : s_ready_a;
    assign mv_w      = sel4 ? m_valid_b : m_valid_a;
    assign md_w      = sel4 ? m_data_b  : m_data_a;
    assign ml_w      = sel4 ? m_eol_b   : m_eol_a;
    assign mf_w      = sel4 ? m_eof_b   : m_eof_a;
    assign fe_w      = sel4 ? frame_err_b : frame_err_a;

    param_down_sampler #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .FACTOR(2), .FIFO_DEPTH(4)) dut_f2 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .s_sof(s_sof), .mode(mode), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_eol(m_eol_a), .m_eof(m_eof_a), .frame_err(frame_err_a));

    param_down_sampler #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .FACTOR(4), .FIFO_DEPTH(4)) dut_f4 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_sof(s_sof), .mode(mode), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_eol(m_eol_b), .m_eof(m_eof_b), .frame_err(frame_err_b));

    int n_checks = 0;
    int n_pass   = 0;
    int px_accepted = 0;
    int err_pulses  = 0;
    int got_q[$];   // data + 256*eol + 512*eof

    always @(negedge clk) begin
        if (rst === 1'b1 && mv_w === 1'b1 && m_ready === 1'b1)
            got_q.push_back(int'(md_w) + (ml_w ? 256 : 0) + (mf_w ? 512 : 0));
        if (rst === 1'b1 && fe_w === 1'b1) err_pulses++;
    end

    task automatic send_pixel(input int pix, input bit sof);
        int waited = 0;
        s_data  = 8'(pix);
        s_sof   = sof;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_w === 1'b1) break;
            waited++;
            if (waited > 300) begin
                n_checks++;
                $display("FAIL send_timeout s_ready=%b after %0d cycles, required 1", s_ready_w, waited);
                s_valid = 1'b0;
                s_sof   = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        px_accepted++;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit all255, input bit mode_sof, input bit mode_rest);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                mode = (r == 0 && c == 0) ? mode_sof : mode_rest;
                send_pixel(all255 ? 255 : c + 10 * r, r == 0 && c == 0);
            end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (mv_w === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (mv_w !== 1'b0) $display("FAIL drain_timeout m_valid=%b, required 0", mv_w); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; mode = 1'b0;
        m_ready = 1'b1; sel4 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (m_valid_a !== 1'b0) $display("FAIL rst_m_valid got %b expected 0", m_valid_a); else n_pass++;
        n_checks++; if (m_eol_a !== 1'b0) $display("FAIL rst_m_eol got %b expected 0", m_eol_a); else n_pass++;
        n_checks++; if (m_eof_a !== 1'b0) $display("FAIL rst_m_eof got %b expected 0", m_eof_a); else n_pass++;
        n_checks++; if (frame_err_a !== 1'b0) $display("FAIL rst_frame_err got %b expected 0", frame_err_a); else n_pass++;
        n_checks++; if (m_valid_b !== 1'b0) $display("FAIL rst_m_valid_f4 got %b expected 0", m_valid_b); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (s_ready_a !== 1'b1) $display("FAIL rst_s_ready got %b expected 1", s_ready_a); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_decimate();
        int exp_c[8] = '{0, 2, 4, 6 + 256, 20, 22, 24, 26 + 768};
        got_q.delete(); err_pulses = 0;
        mode = 1'b0;
        send_pixel(0, 1'b1);
        n_checks++; if (m_valid_a !== 1'b1) $display("FAIL dec_latency_valid got %b expected 1", m_valid_a); else n_pass++;
        n_checks++; if (m_data_a !== 8'd0) $display("FAIL dec_latency_data got %0d expected 0", m_data_a); else n_pass++;
        mode = 1'b1;   // must not affect the current frame
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                if (r != 0 || c != 0) send_pixel(c + 10 * r, 1'b0);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) $display("FAIL dec_count got %0d expected 8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL dec_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
        n_checks++; if (err_pulses !== 0) $display("FAIL dec_frame_err got %0d expected 0", err_pulses); else n_pass++;
    endtask

    task automatic test_average();
        int exp_c[8] = '{5, 7, 9, 11 + 256, 25, 27, 29, 31 + 768};
        got_q.delete();
        send_frame(1'b0, 1'b1, 1'b0);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) $display("FAIL avg_count got %0d expected 8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL avg_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int exp_c[8] = '{0, 2, 4, 6 + 256, 20, 22, 24, 26 + 768};
        got_q.delete(); px_accepted = 0;
        m_ready = 1'b0;
        fork
            send_frame(1'b0, 1'b0, 1'b0);
            begin
                repeat (40) @(negedge clk);
                n_checks++; if (s_ready_a !== 1'b0) $display("FAIL bp_s_ready got %b expected 0", s_ready_a); else n_pass++;
                n_checks++; if (px_accepted !== 7) $display("FAIL bp_accepted got %0d expected 7", px_accepted); else n_pass++;
                n_checks++; if (m_valid_a !== 1'b1) $display("FAIL bp_m_valid got %b expected 1", m_valid_a); else n_pass++;
                n_checks++; if (m_data_a !== 8'd0) $display("FAIL bp_head got %0d expected 0", m_data_a); else n_pass++;
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++; if (got_q.size() !== 8) $display("FAIL bp_count got %0d expected 8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL bp_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_sof_error();
        int exp_c[12] = '{0, 2, 4, 6 + 256, 0, 2, 4, 6 + 256, 20, 22, 24, 26 + 768};
        got_q.delete(); err_pulses = 0;
        mode = 1'b0;
        for (int c = 0; c < 8; c++) send_pixel(c, c == 0);
        for (int c = 0; c < 3; c++) send_pixel(c + 10, 1'b0);
        send_frame(1'b0, 1'b0, 1'b0);   // its s_sof lands on pixel (3,1)
        wait_drain();
        n_checks++; if (err_pulses !== 1) $display("FAIL sof_frame_err got %0d expected 1", err_pulses); else n_pass++;
        n_checks++; if (got_q.size() !== 12) $display("FAIL sof_count got %0d expected 12", got_q.size()); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL sof_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
    endtask

    task automatic test_factor4();
        int exp_c[2] = '{255, 255 + 768};
        got_q.delete();
        sel4 = 1'b1;
        send_frame(1'b1, 1'b1, 1'b1);
        wait_drain();
        n_checks++; if (got_q.size() !== 2) $display("FAIL f4_count got %0d expected 2", got_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL f4_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
        sel4 = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int exp_c[8] = '{0, 2, 4, 6 + 256, 20, 22, 24, 26 + 768};
        got_q.delete(); err_pulses = 0;
        m_ready = 1'b0; mode = 1'b0;
        for (int c = 0; c < 6; c++) send_pixel(c, c == 0);
        n_checks++; if (m_valid_a !== 1'b1) $display("FAIL mrst_pre_valid got %b expected 1", m_valid_a); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (m_valid_a !== 1'b0) $display("FAIL mrst_m_valid got %b expected 0", m_valid_a); else n_pass++;
        n_checks++; if ({m_eol_a, m_eof_a} !== 2'b00) $display("FAIL mrst_flags got %b expected 00", {m_eol_a, m_eof_a}); else n_pass++;
        n_checks++; if (s_ready_a !== 1'b1) $display("FAIL mrst_s_ready got %b expected 1", s_ready_a); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;
        px_accepted = 0;
        for (int c = 6; c < 11; c++) send_pixel(c, 1'b0);
        wait_drain();
        n_checks++; if (px_accepted !== 5) $display("FAIL mrst_drop_accepted got %0d expected 5", px_accepted); else n_pass++;
        n_checks++; if (got_q.size() !== 0) $display("FAIL mrst_dropped_out got %0d expected 0", got_q.size()); else n_pass++;
        send_frame(1'b0, 1'b0, 1'b0);
        wait_drain();
        n_checks++; if (got_q.size() !== 8) $display("FAIL mrst_count got %0d expected 8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            int act;
            act = (i < got_q.size()) ? got_q[i] : -1;
            n_checks++;
            if (act !== exp_c[i]) $display("FAIL mrst_out[%0d] got 0x%0h expected 0x%0h", i, act, exp_c[i]); else n_pass++;
        end
        n_checks++; if (err_pulses !== 0) $display("FAIL mrst_frame_err got %0d expected 0", err_pulses); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decimate();
        test_average();
        test_backpressure();
        test_sof_error();
        test_factor4();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
